mem_arbiter: RTL and testbench

- Responder end of the cache-control protocol that dcache and icache drive as initiators.
- Arbitrates between one data-cache port (read/write) and one instruction-cache port (read only), then forwards a single word access to the unified RAM.
- Returns per-port wait/load handshakes; the initiator holds its request stable until its wait signal drops.
- Sits between the caches and the RAM model, inside the memory subsystem.

---
 rtl/cpu_types_pkg.sv | 55 +++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared memory-side types: data word, RAM handshake state, arbiter state and RAM command bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2,
    GAP    = 2'd3
  } arbstate_t;

  localparam word_t ERR_WORD = 32'hBAD1BAD1;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_cmd_t;

  localparam ram_cmd_t RAM_IDLE = '{ren: 1'b0, wen: 1'b0, addr: 32'd0, store: 32'd0};

  // ERROR also ends an access; the initiator is released either way
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

  // A write wins over a read when the dcache raises both
  function automatic ram_cmd_t data_cmd(input logic wen, input word_t addr, input word_t store);
    ram_cmd_t c;
    c.ren   = ~wen;
    c.wen   = wen;
    c.addr  = addr;
    c.store = wen ? store : 32'd0;
    return c;
  endfunction

  function automatic ram_cmd_t instr_cmd(input word_t addr);
    ram_cmd_t c;
    c.ren   = 1'b1;
    c.wen   = 1'b0;
    c.addr  = addr;
    c.store = 32'd0;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// dcache/icache to unified RAM arbiter with bounded icache starvation.
// Optional per-port completion counters: define MEM_ARBITER_STATS_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 32'd4,
  parameter word_t       ERR_WORD   = cpu_types_pkg::ERR_WORD
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
`ifdef MEM_ARBITER_STATS_EN
  ,
  output word_t     dcount,
  output word_t     icount
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arbstate_t  state;
  logic [3:0] starve;
  ram_cmd_t   cmd;
  logic       d_req;
  logic       d_done;
  logic       i_done;
  logic       d_first;

  assign d_req  = dREN | dWEN;
  assign d_done = (state == DSERVE) && d_req && ram_done(ramstate);
  assign i_done = (state == ISERVE) && iREN && ram_done(ramstate);
  // Data wins contention unless the icache has already been passed over STARVE_MAX times
  assign d_first = d_req && !(iREN && (starve == STARVE_LIM));

  // Completion is visible in the same cycle the RAM reports it
  assign dwait = ~d_done;
  assign iwait = ~i_done;

  assign ramREN   = cmd.ren;
  assign ramWEN   = cmd.wen;
  assign ramaddr  = cmd.addr;
  assign ramstore = cmd.store;

  // Arbiter FSM, starvation counter, registered RAM command and load/error registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= 4'd0;
      cmd    <= RAM_IDLE;
      dload  <= 32'd0;
      iload  <= 32'd0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_first) begin
            state <= DSERVE;
            cmd   <= data_cmd(dWEN, daddr, dstore);
            if (iREN) begin
              starve <= (starve == STARVE_LIM) ? starve : starve + 4'd1;
            end else begin
              starve <= 4'd0;
            end
          end else if (iREN) begin
            state  <= ISERVE;
            cmd    <= instr_cmd(iaddr);
            starve <= 4'd0;
          end else begin
            state  <= IDLE;
            cmd    <= RAM_IDLE;
            starve <= 4'd0;
          end
        end
        DSERVE: begin
          if (!d_req) begin
            state <= IDLE;
            cmd   <= RAM_IDLE;
          end else if (d_done) begin
            state <= GAP;
            cmd   <= RAM_IDLE;
            if (!dWEN) begin
              dload <= (ramstate == ERROR) ? ERR_WORD : ramload;
            end
            if (ramstate == ERROR) begin
              err <= 1'b1;
            end
          end else begin
            state <= DSERVE;
            cmd   <= data_cmd(dWEN, daddr, dstore);
          end
        end
        ISERVE: begin
          if (!iREN) begin
            state <= IDLE;
            cmd   <= RAM_IDLE;
          end else if (i_done) begin
            state <= GAP;
            cmd   <= RAM_IDLE;
            iload <= (ramstate == ERROR) ? ERR_WORD : ramload;
            if (ramstate == ERROR) begin
              err <= 1'b1;
            end
          end else begin
            state <= ISERVE;
            cmd   <= instr_cmd(iaddr);
          end
        end
        GAP: begin
          state <= IDLE;
          cmd   <= RAM_IDLE;
        end
        default: begin
          state <= IDLE;
          cmd   <= RAM_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  // Completed (non-aborted) accesses per port, free-running with wrap
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dcount <= 32'd0;
      icount <= 32'd0;
    end else begin
      if (d_done) begin
        dcount <= dcount + 32'd1;
      end
      if (i_done) begin
        icount <= icount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic      CLK = 1'b0;
  logic      nRST = 1'b0;
  logic      dREN = 1'b0, dWEN = 1'b0, iREN = 1'b0;
  word_t     daddr = 32'd0, dstore = 32'd0, iaddr = 32'd0;
  logic      dwait, iwait, ramREN, ramWEN, err;
  word_t     dload, iload, ramaddr, ramstore, ramload;
  ramstate_t ramstate = FREE;
`ifdef MEM_ARBITER_STATS_EN
  word_t     dcount, icount;
`endif

  // RAM responder knobs
  int        busy_n = 0;
  int        en_cnt = 0;
  ramstate_t ram_mode = ACCESS;
  word_t     ram_data = 32'd0;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
`ifdef MEM_ARBITER_STATS_EN
    , .dcount(dcount), .icount(icount)
`endif
  );

  always #5 CLK = ~CLK;

  assign ramload = ram_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // RAM model: BUSY for busy_n enabled cycles, then ram_mode
  always @(posedge CLK) begin
    #1;
    if (ramREN || ramWEN) begin
      ramstate = (en_cnt >= busy_n) ? ram_mode : BUSY;
      en_cnt++;
    end else begin
      ramstate = FREE;
      en_cnt = 0;
    end
  end

  // Reference model: who owns the RAM, starvation tally, results of completed accesses
  int    m_owner = 0;  // 0 nobody, 1 dcache, 2 icache
  bit    m_gap = 1'b0;
  int    m_starve = 0;
  word_t m_dload = 32'd0, m_iload = 32'd0;
  bit    m_err = 1'b0;
  logic  m_ren = 1'b0, m_wen = 1'b0;
  word_t m_addr = 32'd0, m_store = 32'd0;
  word_t m_dcount = 32'd0, m_icount = 32'd0;
  bit    pre_dreq, pre_done;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner = 0; m_gap = 1'b0; m_starve = 0;
      m_dload = 32'd0; m_iload = 32'd0; m_err = 1'b0;
      m_ren = 1'b0; m_wen = 1'b0; m_addr = 32'd0; m_store = 32'd0;
      m_dcount = 32'd0; m_icount = 32'd0;
    end else begin
      pre_dreq = dREN || dWEN;
      pre_done = (ramstate == ACCESS) || (ramstate == ERROR);
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_owner == 1) begin
        if (!pre_dreq) m_owner = 0;
        else if (pre_done) begin
          if (!dWEN) m_dload = (ramstate == ERROR) ? 32'hBAD1BAD1 : ramload;
          if (ramstate == ERROR) m_err = 1'b1;
          m_dcount = m_dcount + 32'd1;
          m_owner = 0; m_gap = 1'b1;
        end
      end else if (m_owner == 2) begin
        if (!iREN) m_owner = 0;
        else if (pre_done) begin
          m_iload = (ramstate == ERROR) ? 32'hBAD1BAD1 : ramload;
          if (ramstate == ERROR) m_err = 1'b1;
          m_icount = m_icount + 32'd1;
          m_owner = 0; m_gap = 1'b1;
        end
      end else begin
        if (!iREN) m_starve = 0;
        if (pre_dreq && !(iREN && m_starve >= SMAX)) begin
          m_owner = 1;
          if (iREN && m_starve < SMAX) m_starve++;
        end else if (iREN) begin
          m_owner = 2;
          m_starve = 0;
        end
      end
      m_ren   = (m_owner == 2) || (m_owner == 1 && !dWEN);
      m_wen   = (m_owner == 1) && dWEN;
      m_addr  = (m_owner == 1) ? daddr : ((m_owner == 2) ? iaddr : 32'd0);
      m_store = (m_owner == 1 && dWEN) ? dstore : 32'd0;
    end
  end

  // Every-cycle comparison against the model
  logic exp_dw, exp_iw;
  always @(negedge CLK) begin
    exp_dw = !(m_owner == 1 && (dREN || dWEN) && (ramstate == ACCESS || ramstate == ERROR));
    exp_iw = !(m_owner == 2 && iREN && (ramstate == ACCESS || ramstate == ERROR));
    chk("dwait", {31'd0, dwait}, {31'd0, exp_dw});
    chk("iwait", {31'd0, iwait}, {31'd0, exp_iw});
    chk("dload", dload, m_dload);
    chk("iload", iload, m_iload);
    chk("ramREN", {31'd0, ramREN}, {31'd0, m_ren});
    chk("ramWEN", {31'd0, ramWEN}, {31'd0, m_wen});
    chk("ramaddr", ramaddr, m_addr);
    chk("ramstore", ramstore, m_store);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("waits_not_both_low", {31'd0, (dwait || iwait)}, 32'd1);
`ifdef MEM_ARBITER_STATS_EN
    chk("dcount", dcount, m_dcount);
    chk("icount", icount, m_icount);
`endif
  end

  // Event tallies for hand-computed expectations
  int  dwait_lows = 0, iwait_lows = 0, ren_cycles = 0, wen_cycles = 0;
  byte order_log[$];
  always @(negedge CLK) begin
    if (!dwait) begin dwait_lows++; order_log.push_back(8'h44); end
    if (!iwait) begin iwait_lows++; order_log.push_back(8'h49); end
    if (ramREN) ren_cycles++;
    if (ramWEN) wen_cycles++;
  end

  task automatic clr();
    dwait_lows = 0; iwait_lows = 0; ren_cycles = 0; wen_cycles = 0;
    order_log.delete();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for the selected port's wait to drop; n = negedges taken
  task automatic wait_low(input bit port_i, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge CLK);
      n++;
      if (port_i ? !iwait : !dwait) seen = 1'b1;
    end
    chk(port_i ? "iwait_seen" : "dwait_seen", {31'd0, seen}, 32'd1);
  endtask

  string exp_order = "DDDDIDDDDI";
  int    n;

  initial begin
    #22 nRST = 1'b1;
    tick();
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);

    // Plain data read, immediate ACCESS
    clr(); busy_n = 0; ram_mode = ACCESS; ram_data = 32'hCAFE0001;
    dREN = 1'b1; daddr = 32'h100;
    wait_low(1'b0, n);
    chk("rd_latency", n, 32'd2);
    tick(); dREN = 1'b0;
    repeat (3) tick();
    chk("rd_dwait_pulses", dwait_lows, 32'd1);
    chk("rd_dload_held", dload, 32'hCAFE0001);

    // Write with three BUSY cycles
    clr(); busy_n = 3; ram_data = 32'h0;
    dWEN = 1'b1; dstore = 32'h12345678; daddr = 32'h3100;
    wait_low(1'b0, n);
    tick(); dWEN = 1'b0;
    repeat (3) tick();
    chk("wr_wen_cycles", wen_cycles, 32'd4);
    chk("wr_ren_cycles", ren_cycles, 32'd0);
    chk("wr_dwait_pulses", dwait_lows, 32'd1);
    chk("wr_dload_kept", dload, 32'hCAFE0001);

    // Contention with both requests held
    clr(); busy_n = 0; ram_data = 32'h00000055;
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h400;
    for (int k = 0; k < 200 && order_log.size() < 10; k++) @(negedge CLK);
    tick(); dREN = 1'b0; iREN = 1'b0;
    chk("cont_grants", order_log.size(), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < order_log.size())
        chk("cont_order", {24'd0, order_log[k]}, {24'd0, exp_order[k]});
    end
    chk("cont_iload", iload, 32'h00000055);
    repeat (2) tick();

    // icache abort during BUSY
    clr(); busy_n = 100;
    iREN = 1'b1; iaddr = 32'h800;
    tick(); tick();
    iREN = 1'b0;
    @(negedge CLK);
    chk("abort_ren_hold", {31'd0, ramREN}, 32'd1);
    tick();
    @(negedge CLK);
    chk("abort_ren_drop", {31'd0, ramREN}, 32'd0);
    chk("abort_no_iwait", iwait_lows, 32'd0);
    tick();

    // RAM error on a data read, then a good read
    clr(); busy_n = 0; ram_mode = ERROR; ram_data = 32'h77777777;
    dREN = 1'b1; daddr = 32'h104;
    wait_low(1'b0, n);
    tick(); dREN = 1'b0; ram_mode = ACCESS;
    tick();
    chk("err_dload", dload, 32'hBAD1BAD1);
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_dwait_pulses", dwait_lows, 32'd1);
    ram_data = 32'h00001234;
    dREN = 1'b1; daddr = 32'h108;
    wait_low(1'b0, n);
    tick(); dREN = 1'b0;
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);
    chk("err_good_dload", dload, 32'h00001234);

    // Reset in the middle of a BUSY data access
    clr(); busy_n = 100; ram_data = 32'h0000BEEF;
    dREN = 1'b1; daddr = 32'h10C;
    tick(); tick();
    #1 nRST = 1'b0;
    #1;
    chk("mid_rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("mid_rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("mid_rst_dload", dload, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_dwait", {31'd0, dwait}, 32'd1);
    chk("mid_rst_iwait", {31'd0, iwait}, 32'd1);
    @(posedge CLK);
    #2 nRST = 1'b1;
    busy_n = 0;
    wait_low(1'b0, n);
    tick(); dREN = 1'b0;
    tick();
    chk("restart_dload", dload, 32'h0000BEEF);
    chk("restart_dwait_pulses", dwait_lows, 32'd1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
